wave_sequencer: RTL and testbench

- Controller that sequences the waveform generators (triangle/square/sawtooth) through a programmable table of segments.
- Each segment holds: waveform select, amplitude, prescaler, repeat count.
- Drives generator enable and configuration. Changes configuration only at a waveform period boundary, so the output has no glitches.
- Sits between the host/UI register interface and the generator bank. Generator outputs are muxed by gen_sel downstream.

---
 rtl/wave_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_wave_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sequencer.sv
// wave_sequencer
//   Steps the waveform generator bank through a programmable table of
//   segments. Each segment holds a waveform select, an amplitude, a prescaler
//   and a repeat count. The active configuration is only changed while the
//   generator sits at a period boundary, so its output never glitches.
//
// Optional feature (compile-time macro WAVE_SEQ_LIVE_UPDATE_EN):
//   defined   -> table entries other than the active one may be rewritten
//                while a sequence is running
//   undefined -> the table is only writable while idle
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   cfg_we/addr/...   segment table write port, accepted when cfg_we && cfg_ready
//   cfg_ready         table write is accepted this cycle
//   start             pulse: play the table from segment 0
//   stop              pulse: finish the current period, then halt
//   loop              level: wrap to segment 0 at the end of the table
//   gen_period_done   pulse from the active generator at its period boundary
//   gen_ena/sel/amplitude/prescaler  active generator configuration
//   seg_idx           active segment index
//   busy              sequencer is loading, running or draining
//   seq_done          one-cycle pulse as the sequencer returns to idle
module wave_sequencer #(
  parameter int unsigned NUM_SEG = 4,
  parameter int unsigned SEG_AW  = 2,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [SEG_AW-1:0] cfg_addr,
  input  logic [1:0]        cfg_sel,
  input  logic [DATA_W-1:0] cfg_amp,
  input  logic [DATA_W-1:0] cfg_psc,
  input  logic [7:0]        cfg_reps,
  output logic              cfg_ready,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic              gen_period_done,
  output logic              gen_ena,
  output logic [1:0]        gen_sel,
  output logic [DATA_W-1:0] gen_amplitude,
  output logic [DATA_W-1:0] gen_prescaler,
  output logic [SEG_AW-1:0] seg_idx,
  output logic              busy,
  output logic              seq_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [SEG_AW-1:0] LAST_SEG = SEG_AW'(NUM_SEG - 1);

  // Segment table
  logic [1:0]        tbl_sel  [NUM_SEG];
  logic [DATA_W-1:0] tbl_amp  [NUM_SEG];
  logic [DATA_W-1:0] tbl_psc  [NUM_SEG];
  logic [7:0]        tbl_reps [NUM_SEG];

  state_t            state, state_n;
  logic [SEG_AW-1:0] seg_idx_n;
  logic              gen_ena_n;
  logic [1:0]        gen_sel_n;
  logic [DATA_W-1:0] gen_amp_n;
  logic [DATA_W-1:0] gen_psc_n;
  logic [7:0]        rep_cnt, rep_cnt_n;
  logic              seq_done_n;
  logic              stop_pend, stop_pend_n;
  logic              stop_eff;
  logic [1:0]        cur_sel;
  logic [DATA_W-1:0] cur_amp;
  logic [DATA_W-1:0] cur_psc;
  logic [7:0]        cur_reps;

  assign busy = (state != S_IDLE);

`ifdef WAVE_SEQ_LIVE_UPDATE_EN
  // The active entry stays locked so the segment being played is never torn.
  assign cfg_ready = !busy || (cfg_addr != seg_idx);
`else
  assign cfg_ready = !busy;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SEG; i++) begin
        tbl_sel[i]  <= '0;
        tbl_amp[i]  <= '0;
        tbl_psc[i]  <= '0;
        tbl_reps[i] <= '0;
      end
    end else if (cfg_we && cfg_ready) begin
      tbl_sel[cfg_addr]  <= cfg_sel;
      tbl_amp[cfg_addr]  <= cfg_amp;
      tbl_psc[cfg_addr]  <= cfg_psc;
      tbl_reps[cfg_addr] <= cfg_reps;
    end
  end

  assign cur_sel  = tbl_sel[seg_idx];
  assign cur_amp  = tbl_amp[seg_idx];
  assign cur_psc  = tbl_psc[seg_idx];
  assign cur_reps = tbl_reps[seg_idx];

  // A stop seen during the single LOAD cycle is remembered so it is not lost.
  assign stop_eff = stop || stop_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      seg_idx       <= '0;
      gen_ena       <= 1'b0;
      gen_sel       <= '0;
      gen_amplitude <= '0;
      gen_prescaler <= '0;
      rep_cnt       <= '0;
      seq_done      <= 1'b0;
      stop_pend     <= 1'b0;
    end else begin
      state         <= state_n;
      seg_idx       <= seg_idx_n;
      gen_ena       <= gen_ena_n;
      gen_sel       <= gen_sel_n;
      gen_amplitude <= gen_amp_n;
      gen_prescaler <= gen_psc_n;
      rep_cnt       <= rep_cnt_n;
      seq_done      <= seq_done_n;
      stop_pend     <= stop_pend_n;
    end
  end

  always_comb begin
    state_n     = state;
    seg_idx_n   = seg_idx;
    gen_ena_n   = gen_ena;
    gen_sel_n   = gen_sel;
    gen_amp_n   = gen_amplitude;
    gen_psc_n   = gen_prescaler;
    rep_cnt_n   = rep_cnt;
    seq_done_n  = 1'b0;
    stop_pend_n = stop_pend;

    case (state)
      S_IDLE: begin
        stop_pend_n = 1'b0;
        if (start) begin
          state_n   = S_LOAD;
          seg_idx_n = '0;
        end
      end

      S_LOAD: begin
        if (stop) stop_pend_n = 1'b1;
        if (cur_reps == '0) begin
          // Empty entry marks the end of the table
          if (seg_idx == '0 || !loop || stop_eff) begin
            state_n     = S_IDLE;
            gen_ena_n   = 1'b0;
            seq_done_n  = 1'b1;
            rep_cnt_n   = '0;
            stop_pend_n = 1'b0;
          end else begin
            seg_idx_n = '0;
          end
        end else begin
          gen_sel_n = (cur_sel == 2'd3) ? 2'd0 : cur_sel;
          gen_amp_n = cur_amp;
          gen_psc_n = cur_psc;
          rep_cnt_n = cur_reps;
          gen_ena_n = 1'b1;
          state_n   = S_RUN;
        end
      end

      S_RUN: begin
        if (stop_eff && gen_period_done) begin
          state_n     = S_IDLE;
          gen_ena_n   = 1'b0;
          seq_done_n  = 1'b1;
          rep_cnt_n   = '0;
          stop_pend_n = 1'b0;
        end else if (stop_eff) begin
          state_n = S_DRAIN;
        end else if (gen_period_done) begin
          if (rep_cnt <= 8'd1) begin
            rep_cnt_n = '0;
            // Rolling over the last index is handled here, as an end of table
            if (seg_idx == LAST_SEG) begin
              if (loop) begin
                seg_idx_n = '0;
                state_n   = S_LOAD;
              end else begin
                state_n    = S_IDLE;
                gen_ena_n  = 1'b0;
                seq_done_n = 1'b1;
              end
            end else begin
              seg_idx_n = seg_idx + 1'b1;
              state_n   = S_LOAD;
            end
          end else begin
            rep_cnt_n = rep_cnt - 8'd1;
          end
        end
      end

      S_DRAIN: begin
        if (gen_period_done) begin
          state_n     = S_IDLE;
          gen_ena_n   = 1'b0;
          seq_done_n  = 1'b1;
          rep_cnt_n   = '0;
          stop_pend_n = 1'b0;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wave_sequencer.sv
module tb_wave_sequencer;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_amp;
  logic [15:0] cfg_psc;
  logic [7:0]  cfg_reps;
  logic        cfg_ready;
  logic        start;
  logic        stop;
  logic        loop;
  logic        gen_period_done;
  logic        gen_ena;
  logic [1:0]  gen_sel;
  logic [15:0] gen_amplitude;
  logic [15:0] gen_prescaler;
  logic [1:0]  seg_idx;
  logic        busy;
  logic        seq_done;

  int checks = 0;
  int errors = 0;

`ifdef WAVE_SEQ_LIVE_UPDATE_EN
  localparam logic        LIVE = 1'b1;
`else
  localparam logic        LIVE = 1'b0;
`endif

  wave_sequencer #(.NUM_SEG(4), .SEG_AW(2), .DATA_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_sel         (cfg_sel),
    .cfg_amp         (cfg_amp),
    .cfg_psc         (cfg_psc),
    .cfg_reps        (cfg_reps),
    .cfg_ready       (cfg_ready),
    .start           (start),
    .stop            (stop),
    .loop            (loop),
    .gen_period_done (gen_period_done),
    .gen_ena         (gen_ena),
    .gen_sel         (gen_sel),
    .gen_amplitude   (gen_amplitude),
    .gen_prescaler   (gen_prescaler),
    .seg_idx         (seg_idx),
    .busy            (busy),
    .seq_done        (seq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] s, input logic [15:0] amp,
                    input logic [15:0] psc, input logic [7:0] reps);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_sel  = s;
    cfg_amp  = amp;
    cfg_psc  = psc;
    cfg_reps = reps;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic pulse_pd();
    gen_period_done = 1'b1;
    tick();
    gen_period_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0; cfg_amp = '0; cfg_psc = '0; cfg_reps = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; gen_period_done = 1'b0;
    #12;
    chk("rst_gen_ena", 32'(gen_ena), 0);
    chk("rst_gen_sel", 32'(gen_sel), 0);
    chk("rst_amp", 32'(gen_amplitude), 0);
    chk("rst_psc", 32'(gen_prescaler), 0);
    chk("rst_seg_idx", 32'(seg_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_seq_done", 32'(seq_done), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    rst = 1'b0;

    // Basic sequence, with a write to seg1 attempted while seg0 plays
    wr(2'd0, 2'd0, 16'd100, 16'd3, 8'd2);
    wr(2'd1, 2'd2, 16'd50, 16'd0, 8'd1);
    wr(2'd2, 2'd0, 16'd0, 16'd0, 8'd0);
    pulse_start();
    chk("t1_load_busy", 32'(busy), 1);
    chk("t1_load_ena", 32'(gen_ena), 0);
    tick();
    chk("t1_run_ena", 32'(gen_ena), 1);
    chk("t1_run_sel", 32'(gen_sel), 0);
    chk("t1_run_amp", 32'(gen_amplitude), 100);
    chk("t1_run_psc", 32'(gen_prescaler), 3);
    chk("t1_run_seg", 32'(seg_idx), 0);
    cfg_addr = 2'd0;
    #1;
    chk("t1_ready_active", 32'(cfg_ready), 0);
    cfg_addr = 2'd1;
    #1;
    chk("t1_ready_inactive", 32'(cfg_ready), 32'(LIVE));
    wr(2'd1, 2'd2, 16'd77, 16'd0, 8'd1);
    pulse_pd();
    chk("t1_pd1_amp", 32'(gen_amplitude), 100);
    chk("t1_pd1_seg", 32'(seg_idx), 0);
    pulse_pd();
    chk("t1_pd2_seg", 32'(seg_idx), 1);
    chk("t1_pd2_sel_held", 32'(gen_sel), 0);
    chk("t1_pd2_amp_held", 32'(gen_amplitude), 100);
    chk("t1_pd2_ena", 32'(gen_ena), 1);
    tick();
    chk("t1_seg1_sel", 32'(gen_sel), 2);
    chk("t1_seg1_amp", 32'(gen_amplitude), LIVE ? 77 : 50);
    chk("t1_seg1_psc", 32'(gen_prescaler), 0);
    pulse_pd();
    chk("t1_pd3_seg", 32'(seg_idx), 2);
    chk("t1_pd3_done", 32'(seq_done), 0);
    tick();
    chk("t1_end_done", 32'(seq_done), 1);
    chk("t1_end_ena", 32'(gen_ena), 0);
    chk("t1_end_busy", 32'(busy), 0);
    tick();
    chk("t1_done_pulse", 32'(seq_done), 0);

    // Looping, then stop and drain
    wr(2'd1, 2'd2, 16'd50, 16'd0, 8'd1);
    loop = 1'b1;
    pulse_start();
    tick();
    pulse_pd();
    pulse_pd();
    tick();
    chk("t2_seg1_sel", 32'(gen_sel), 2);
    pulse_pd();
    tick();
    chk("t2_wrap_seg", 32'(seg_idx), 0);
    chk("t2_wrap_ena", 32'(gen_ena), 1);
    chk("t2_wrap_done", 32'(seq_done), 0);
    tick();
    chk("t2_wrap_sel", 32'(gen_sel), 0);
    chk("t2_wrap_amp", 32'(gen_amplitude), 100);
    chk("t2_wrap_ena2", 32'(gen_ena), 1);
    pulse_stop();
    chk("t2_drain_busy", 32'(busy), 1);
    pulse_start();
    repeat (4) tick();
    chk("t2_drain_ena", 32'(gen_ena), 1);
    chk("t2_drain_amp", 32'(gen_amplitude), 100);
    pulse_pd();
    chk("t2_halt_ena", 32'(gen_ena), 0);
    chk("t2_halt_done", 32'(seq_done), 1);
    chk("t2_halt_busy", 32'(busy), 0);
    tick();
    chk("t2_done_pulse", 32'(seq_done), 0);
    loop = 1'b0;

    // Full table: reserved select and rollover of the last index
    wr(2'd0, 2'd3, 16'd10, 16'd1, 8'd1);
    wr(2'd1, 2'd1, 16'd20, 16'd2, 8'd1);
    wr(2'd2, 2'd2, 16'd30, 16'd3, 8'd1);
    wr(2'd3, 2'd0, 16'd40, 16'd4, 8'd1);
    pulse_start();
    tick();
    chk("t3_sel_reserved", 32'(gen_sel), 0);
    chk("t3_amp0", 32'(gen_amplitude), 10);
    pulse_pd();
    tick();
    chk("t3_seg1", 32'(seg_idx), 1);
    chk("t3_sel1", 32'(gen_sel), 1);
    pulse_pd();
    tick();
    pulse_pd();
    tick();
    chk("t3_seg3", 32'(seg_idx), 3);
    chk("t3_amp3", 32'(gen_amplitude), 40);
    pulse_pd();
    chk("t3_roll_done", 32'(seq_done), 1);
    chk("t3_roll_ena", 32'(gen_ena), 0);
    chk("t3_roll_busy", 32'(busy), 0);
    tick();

    // stop and period boundary together
    pulse_start();
    tick();
    chk("t4_run_ena", 32'(gen_ena), 1);
    stop = 1'b1;
    gen_period_done = 1'b1;
    tick();
    stop = 1'b0;
    gen_period_done = 1'b0;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_ena", 32'(gen_ena), 0);
    chk("t4_done", 32'(seq_done), 1);
    tick();
    chk("t4_done_pulse", 32'(seq_done), 0);
    pulse_pd();
    chk("t4_late_pd_done", 32'(seq_done), 0);
    chk("t4_late_pd_busy", 32'(busy), 0);

    // start and stop together in IDLE: start wins
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("t5_start_wins", 32'(busy), 1);
    tick();
    chk("t5_run_ena", 32'(gen_ena), 1);

    // Asynchronous reset mid-run clears everything including the table
    rst = 1'b1;
    #2;
    chk("t6_ena", 32'(gen_ena), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_amp", 32'(gen_amplitude), 0);
    chk("t6_psc", 32'(gen_prescaler), 0);
    chk("t6_sel", 32'(gen_sel), 0);
    chk("t6_seg", 32'(seg_idx), 0);
    chk("t6_ready", 32'(cfg_ready), 1);
    #1;
    rst = 1'b0;
    pulse_start();
    chk("t6_empty_busy", 32'(busy), 1);
    chk("t6_empty_done0", 32'(seq_done), 0);
    tick();
    chk("t6_empty_done", 32'(seq_done), 1);
    chk("t6_empty_ena", 32'(gen_ena), 0);
    chk("t6_empty_busy2", 32'(busy), 0);
    tick();
    chk("t6_empty_pulse", 32'(seq_done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
